// File: rtl/seq_divider_16by8_if.sv
// Valid/ready bundle between a divider client and the divider.
// master drives operands and accepts results; slave is the divider.
interface seq_divider_16by8_if #(
   parameter int DIVIDEND_W = 16,
   parameter int DIVISOR_W  = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DIVIDEND_W-1:0] dividend;
   logic [DIVISOR_W-1:0]  divisor;
   logic                  out_valid;
   logic                  out_ready;
   logic [DIVIDEND_W-1:0] quotient;
   logic [DIVISOR_W-1:0]  remainder;
   logic                  div_by_zero;

   modport master (
      output in_valid,
      output dividend,
      output divisor,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  quotient,
      input  remainder,
      input  div_by_zero
   );

   modport slave (
      input  in_valid,
      input  dividend,
      input  divisor,
      input  out_ready,
      output in_ready,
      output out_valid,
      output quotient,
      output remainder,
      output div_by_zero
   );
endinterface

// File: rtl/seq_divider_16by8.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
// Divide by zero short-circuits to all-ones quotient in one cycle.
module seq_divider_16by8 #(
   parameter int DIVIDEND_W = 16,
   parameter int DIVISOR_W  = 8
) (
   input logic                clock,
   input logic                reset,
   seq_divider_16by8_if.slave bus
);

   localparam int CW = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [DIVISOR_W-1:0]  r;
   logic [DIVISOR_W-1:0]  r_nxt;
   logic [DIVIDEND_W-1:0] q;
   logic [DIVIDEND_W-1:0] q_nxt;
   logic [DIVISOR_W-1:0]  dvsr;
   logic [DIVISOR_W-1:0]  dvsr_nxt;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         cnt_nxt;
   logic [DIVIDEND_W-1:0] quo;
   logic [DIVIDEND_W-1:0] quo_nxt;
   logic [DIVISOR_W-1:0]  rem;
   logic [DIVISOR_W-1:0]  rem_nxt;
   logic                  dbz;
   logic                  dbz_nxt;

   logic [DIVISOR_W:0]    p;
   logic [DIVISOR_W-1:0]  diff;
   logic                  ge;

   // p carries the extra top bit so 2*divisor-1 compares correctly.
   assign p    = {r, q[DIVIDEND_W-1]};
   assign ge   = (p >= {1'b0, dvsr});
   // When ge holds, p - dvsr < dvsr, so the low bits are exact.
   assign diff = p[DIVISOR_W-1:0] - dvsr;

   assign bus.quotient    = quo;
   assign bus.remainder   = rem;
   assign bus.div_by_zero = dbz;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         r     <= '0;
         q     <= '0;
         dvsr  <= '0;
         cnt   <= '0;
         quo   <= '0;
         rem   <= '0;
         dbz   <= 1'b0;
      end else begin
         state <= state_nxt;
         r     <= r_nxt;
         q     <= q_nxt;
         dvsr  <= dvsr_nxt;
         cnt   <= cnt_nxt;
         quo   <= quo_nxt;
         rem   <= rem_nxt;
         dbz   <= dbz_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      r_nxt         = r;
      q_nxt         = q;
      dvsr_nxt      = dvsr;
      cnt_nxt       = cnt;
      quo_nxt       = quo;
      rem_nxt       = rem;
      dbz_nxt       = dbz;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;

      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               dvsr_nxt = bus.divisor;
               q_nxt    = bus.dividend;
               r_nxt    = '0;
               if (bus.divisor == '0) begin
                  state_nxt = DONE;
                  quo_nxt   = '1;
                  rem_nxt   = bus.dividend[DIVISOR_W-1:0];
                  dbz_nxt   = 1'b1;
               end else begin
                  state_nxt = CALC;
                  cnt_nxt   = CW'(DIVIDEND_W - 1);
               end
            end
         end

         CALC: begin
            r_nxt   = ge ? diff : p[DIVISOR_W-1:0];
            q_nxt   = {q[DIVIDEND_W-2:0], ge};
            cnt_nxt = cnt - CW'(1);
            if (cnt == '0) begin
               state_nxt = DONE;
               quo_nxt   = {q[DIVIDEND_W-2:0], ge};
               rem_nxt   = ge ? diff : p[DIVISOR_W-1:0];
               dbz_nxt   = 1'b0;
            end
         end

         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
